// File: rtl/mux8_scan_serializer.sv
// Parallel-in/serial-out sequencer for the 8:1 gate-level mux: holds a word on
// i0..i7, steps the select through all eight inputs, and registers y back as a stream.
module mux8_scan_serializer #(
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load_valid,
    output logic       load_ready,
    input  logic [7:0] load_data,
    input  logic       flush,
    output logic [7:0] word,
    output logic       sel1,
    output logic       sel2,
    output logic       sel3,
    input  logic       mux_y,
    output logic       ser_out,
    output logic       ser_valid,
    output logic       ser_last,
    output logic       busy
);

    typedef enum logic {IDLE, SCAN} state_t;

    state_t     state_reg;
    logic [2:0] cnt_reg;
    logic [2:0] cnt_next;
    logic [7:0] word_reg;
    logic [2:0] sel_reg;
    logic       ser_out_reg;
    logic       ser_valid_reg;
    logic       ser_last_reg;
    logic       accept;
    logic [2:0] idx_of [0:7];

    // Scan order table: counter value -> mux input index.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_idx
            assign idx_of[gi] = MSB_FIRST ? 3'(7 - gi) : 3'(gi);
        end
    endgenerate

    assign cnt_next = cnt_reg + 3'd1;

    // Ready only when idle or on the last beat, and never while a flush aborts the scan.
    assign load_ready = rst_n
                        && !(state_reg == SCAN && flush)
                        && (state_reg == IDLE || cnt_reg == 3'd7);
    assign accept = load_valid && load_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            cnt_reg       <= 3'd0;
            word_reg      <= 8'h00;
            sel_reg       <= 3'd0;
            ser_out_reg   <= 1'b0;
            ser_valid_reg <= 1'b0;
            ser_last_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    ser_valid_reg <= 1'b0;
                    ser_last_reg  <= 1'b0;
                    sel_reg       <= 3'd0;
                    if (accept) begin
                        word_reg  <= load_data;
                        cnt_reg   <= 3'd0;
                        sel_reg   <= idx_of[0];
                        state_reg <= SCAN;
                    end
                end
                SCAN: begin
                    if (flush) begin
                        state_reg     <= IDLE;
                        cnt_reg       <= 3'd0;
                        sel_reg       <= 3'd0;
                        ser_valid_reg <= 1'b0;
                        ser_last_reg  <= 1'b0;
                    end else begin
                        // y sampled here still belongs to the word currently held.
                        ser_out_reg   <= mux_y;
                        ser_valid_reg <= 1'b1;
                        ser_last_reg  <= (cnt_reg == 3'd7);
                        if (cnt_reg != 3'd7) begin
                            cnt_reg <= cnt_next;
                            sel_reg <= idx_of[cnt_next];
                        end else if (accept) begin
                            word_reg <= load_data;
                            cnt_reg  <= 3'd0;
                            sel_reg  <= idx_of[0];
                        end else begin
                            state_reg <= IDLE;
                            cnt_reg   <= 3'd0;
                            sel_reg   <= 3'd0;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign word      = word_reg;
    assign sel1      = sel_reg[2];
    assign sel2      = sel_reg[1];
    assign sel3      = sel_reg[0];
    assign ser_out   = ser_out_reg;
    assign ser_valid = ser_valid_reg;
    assign ser_last  = ser_last_reg;
    assign busy      = (state_reg == SCAN);

endmodule

// File: tb/tb_mux8_scan_serializer.sv
// Bench for mux8_scan_serializer: both scan orders side by side, checked every cycle
// against a schedule of expected beats per clock edge, plus a few literal stream checks.
module tb_mux8_scan_serializer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       load_valid = 1'b0;
    logic       flush = 1'b0;
    logic [7:0] load_data = 8'h00;

    logic       load_ready0, sel1_0, sel2_0, sel3_0, mux_y0, ser_out0, ser_valid0, ser_last0, busy0;
    logic       load_ready1, sel1_1, sel2_1, sel3_1, mux_y1, ser_out1, ser_valid1, ser_last1, busy1;
    logic [7:0] word0, word1;

    always #5 clk = ~clk;

    mux8_scan_serializer #(.MSB_FIRST(1'b0)) u0 (
        .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(load_ready0),
        .load_data(load_data), .flush(flush), .word(word0),
        .sel1(sel1_0), .sel2(sel2_0), .sel3(sel3_0), .mux_y(mux_y0),
        .ser_out(ser_out0), .ser_valid(ser_valid0), .ser_last(ser_last0), .busy(busy0)
    );

    mux8_scan_serializer #(.MSB_FIRST(1'b1)) u1 (
        .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(load_ready1),
        .load_data(load_data), .flush(flush), .word(word1),
        .sel1(sel1_1), .sel2(sel2_1), .sel3(sel3_1), .mux_y(mux_y1),
        .ser_out(ser_out1), .ser_valid(ser_valid1), .ser_last(ser_last1), .busy(busy1)
    );

    // The 8:1 mux itself, closing the loop.
    assign mux_y0 = word0[{sel1_0, sel2_0, sel3_0}];
    assign mux_y1 = word1[{sel1_1, sel2_1, sel3_1}];

    int vectors = 0;
    int miscompares = 0;
    int e = 0;
    bit checking = 1'b0;
    bit rst_prev = 1'b0;
    bit accepted = 1'b0;

    // Expected beat per clock edge: valid, beat number 1..8, source word.
    logic       sv [0:4095];
    logic [3:0] sn [0:4095];
    logic [7:0] sw [0:4095];
    logic [7:0] word_m = 8'h00;
    logic [7:0] cap0 = 8'h00, cap1 = 8'h00;
    int         nb0 = 0, nb1 = 0;

    function automatic logic [2:0] idx(input int n, input bit msb);
        return msb ? 3'(7 - n) : 3'(n);
    endfunction

    task automatic chk(input string name, input int k, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s inst%0d edge %0d: got %h expected %h", name, k, e, act, exp);
        end
    endtask

    task automatic check_inst(input int k, input logic [7:0] w, input logic s1, input logic s2,
                              input logic s3, input logic so, input logic vl, input logic ls,
                              input logic b, input logic lr);
        logic       pv;
        logic [2:0] es;
        logic       er;
        pv = sv[e-1];
        chk("ser_valid", k, {7'b0, vl}, {7'b0, pv});
        chk("ser_last", k, {7'b0, ls}, {7'b0, pv && (sn[e-1] == 4'd8)});
        if (pv)
            chk("ser_out", k, {7'b0, so}, {7'b0, sw[e-1][idx(int'(sn[e-1]) - 1, bit'(k))]});
        else if (rst_prev)
            chk("ser_out_rst", k, {7'b0, so}, 8'h00);
        chk("busy", k, {7'b0, b}, {7'b0, sv[e]});
        es = sv[e] ? idx(int'(sn[e]) - 1, bit'(k)) : 3'd0;
        chk("sel", k, {5'b0, s1, s2, s3}, {5'b0, es});
        chk("word", k, w, word_m);
        er = rst_n && (!sv[e] || ((sn[e] == 4'd8) && !flush));
        chk("load_ready", k, {7'b0, lr}, {7'b0, er});
    endtask

    task automatic cyc(input logic rv, input logic lv, input logic [7:0] ld, input logic fl);
        logic ready_m;
        @(negedge clk);
        rst_n = rv;
        load_valid = lv;
        load_data = ld;
        flush = fl;
        #1;
        if (checking) begin
            check_inst(0, word0, sel1_0, sel2_0, sel3_0, ser_out0, ser_valid0, ser_last0, busy0, load_ready0);
            check_inst(1, word1, sel1_1, sel2_1, sel3_1, ser_out1, ser_valid1, ser_last1, busy1, load_ready1);
            if (ser_valid0) begin cap0 = {cap0[6:0], ser_out0}; nb0++; end
            if (ser_valid1) begin cap1 = {cap1[6:0], ser_out1}; nb1++; end
        end
        ready_m = rst_n && (!sv[e] || ((sn[e] == 4'd8) && !flush));
        accepted = 1'b0;
        if (!rst_n) begin
            for (int i = 0; i <= 8; i++) sv[e+i] = 1'b0;
            word_m = 8'h00;
        end else if (flush && sv[e]) begin
            for (int i = 0; i <= 8; i++) sv[e+i] = 1'b0;
        end else if (load_valid && ready_m) begin
            accepted = 1'b1;
            word_m = load_data;
            for (int n = 1; n <= 8; n++) begin
                sv[e+n] = 1'b1;
                sn[e+n] = 4'(n);
                sw[e+n] = load_data;
            end
        end
        rst_prev = !rst_n;
        @(posedge clk);
        e++;
    endtask

    task automatic send(input logic [7:0] d, input int max);
        int t;
        t = 0;
        accepted = 1'b0;
        while (!accepted && t < max) begin
            cyc(1'b1, 1'b1, d, 1'b0);
            t++;
        end
        vectors++;
        if (!accepted) begin
            miscompares++;
            $display("FAIL send_timeout edge %0d: word %h not accepted within %0d cycles", e, d, max);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic clear_caps;
        cap0 = 8'h00; cap1 = 8'h00; nb0 = 0; nb1 = 0;
    endtask

    initial begin
        logic [7:0] d;
        for (int i = 0; i < 4096; i++) begin sv[i] = 1'b0; sn[i] = 4'd0; sw[i] = 8'h00; end

        cyc(1'b0, 1'b0, 8'h00, 1'b0);
        checking = 1'b1;
        cyc(1'b0, 1'b1, 8'h77, 1'b0);
        idle(1);

        clear_caps();
        send(8'hA5, 4);
        idle(9);
        chk("lit_a5_stream", 0, cap0, 8'hA5);
        chk("lit_a5_stream", 1, cap1, 8'hA5);
        chk("lit_a5_beats", 0, 8'(nb0), 8'd8);

        clear_caps();
        send(8'h01, 4);
        idle(9);
        chk("lit_01_stream", 0, cap0, 8'h80);
        chk("lit_01_stream", 1, cap1, 8'h01);

        clear_caps();
        send(8'hFF, 4);
        send(8'h00, 12);
        idle(9);
        chk("lit_b2b_beats", 0, 8'(nb0), 8'd16);
        chk("lit_b2b_tail", 1, cap1, 8'h00);

        clear_caps();
        send(8'hF0, 4);
        idle(3);
        cyc(1'b1, 1'b0, 8'h00, 1'b1);
        idle(2);
        chk("lit_flush_beats", 0, 8'(nb0), 8'd3);

        clear_caps();
        send(8'h3C, 4);
        idle(4);
        cyc(1'b0, 1'b0, 8'h00, 1'b0);
        cyc(1'b0, 1'b1, 8'h99, 1'b0);
        idle(3);
        chk("lit_rst_beats", 1, 8'(nb1), 8'd4);

        send(8'h55, 4);
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 8'hAA, 1'b0);
        send(8'hAA, 12);
        idle(10);

        cyc(1'b1, 1'b1, 8'h5A, 1'b1);
        idle(10);

        d = 8'($urandom);
        for (int i = 0; i < 500; i++) begin
            cyc(($urandom % 64) != 0, 1'($urandom % 2), d, ($urandom % 16) == 0);
            if (accepted) d = 8'($urandom);
        end
        idle(10);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
